// File: rtl/imem_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : imem_arbiter_pkg
// Purpose  : Shared defaults and FSM state encoding for the instruction-memory
//            arbiter and its starvation counter.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package imem_arbiter_pkg;

  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_STARVE_MAX = 4;

  // Arbiter FSM encoding
  localparam int         STATE_W  = 1;
  localparam logic [0:0] ST_BOOT  = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/imem_starve_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : imem_starve_cnt
// Purpose  : Saturating wait counter for the loader; full flags that the
//            loader has waited long enough to be forced a grant.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module imem_starve_cnt
  import imem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic full
);

  localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  MAX_VAL = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] count;

  // Count wait cycles, clear has priority, hold once saturated
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_VAL)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign full = (count == MAX_VAL);

endmodule
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : imem_arbiter
// Purpose  : Shares one synchronous instruction memory between a program
//            loader (writes) and the CPU fetch port (reads). BOOT serves only
//            the loader; RUN favours the CPU but forces a loader grant after
//            STARVE_MAX waiting cycles.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [15:0]       fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              cpu_stall,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  output logic              boot_busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic               run;
  logic               starve_full;
  logic               forced;
  logic               fetch_grant;
  logic               ld_xfer;

  // Upper pc bits wrap the address space and are intentionally dropped
  logic unused_pc_hi;
  assign unused_pc_hi = ^fetch_addr[15:ADDR_W];

  // Reset low forces BOOT behaviour combinationally so no fetch is granted
  // in the reset cycle itself.
  assign run    = (state == ST_RUN) && reset_n;
  assign forced = run && starve_full;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave BOOT after the load-complete pulse; RUN is sticky
  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT: if (ld_done) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_BOOT;
    endcase
  end

  // Outputs: grant decision and memory port steering
  always_comb begin
    boot_busy   = ~run;
    ld_ready    = 1'b1;
    cpu_stall   = 1'b1;
    fetch_grant = 1'b0;
    if (run) begin
      if (forced) begin
        ld_ready  = 1'b1;
        cpu_stall = fetch_req;
      end else begin
        ld_ready    = ~fetch_req;
        cpu_stall   = 1'b0;
        fetch_grant = fetch_req;
      end
    end
    ld_xfer   = ld_valid && ld_ready;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_xfer) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ld_addr;
      mem_wdata = ld_data;
    end else if (fetch_grant) begin
      mem_en    = 1'b1;
      mem_addr  = fetch_addr[ADDR_W-1:0];
    end
  end

  // Read data returns one cycle after the grant
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_valid <= 1'b0;
    end else begin
      fetch_valid <= fetch_grant;
    end
  end

  assign fetch_data = fetch_valid ? mem_rdata : '0;

  imem_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (run && ld_valid && !ld_ready),
    .clr     (ld_xfer || !ld_valid),
    .full    (starve_full)
  );

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_imem_arbiter
// Purpose  : Directed bench for imem_arbiter with a fetch-data scoreboard and
//            a behavioural synchronous RAM on the memory port.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_valid;
  logic [15:0] fetch_data;
  logic        cpu_stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_addr;
  logic [15:0] ld_data;
  logic        ld_done;
  logic        boot_busy;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc    = 0;
  int          passed = 0;
  int          total  = 0;
  logic [15:0] ram [16];

  imem_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .cpu_stall   (cpu_stall),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_done     (ld_done),
    .boot_busy   (boot_busy),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM
  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 16'h0000;
    mem_rdata = 16'h0000;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_fetch(input logic [15:0] data);
    exp_t e;
    e.data = data;
    e.due  = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Monitor: fetch responses must match the scoreboard in order and timing
  always @(negedge clk) begin
    if (fetch_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("fetch_valid_unexpected", 32'(fetch_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("fetch_data", 32'(fetch_data), 32'(e.data));
        chk("fetch_latency", 32'(cyc), 32'(e.due));
      end
    end else begin
      chk("fetch_data_idle_zero", 32'(fetch_data), 32'd0);
      if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        void'(sb_q.pop_front());
        chk("fetch_valid_missing", 32'(fetch_valid), 32'd1);
      end
    end
  end

  initial begin
    reset_n = 1'b0; fetch_req = 1'b1; fetch_addr = 16'h0000;
    ld_valid = 1'b0; ld_addr = 4'd0; ld_data = 16'h0000; ld_done = 1'b0;

    // Reset held, fetch requested: everything quiet, BOOT outputs
    next_cycle;
    #1;
    chk("rst_cpu_stall", 32'(cpu_stall), 32'd1);
    chk("rst_boot_busy", 32'(boot_busy), 32'd1);
    chk("rst_ld_ready",  32'(ld_ready),  32'd1);
    chk("rst_mem_en",    32'(mem_en),    32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);

    // BOOT: loader write 0x1234@3 while CPU keeps asking for pc 0
    next_cycle;
    reset_n = 1'b1; ld_valid = 1'b1; ld_addr = 4'd3; ld_data = 16'h1234;
    #1;
    chk("boot_cpu_stall", 32'(cpu_stall), 32'd1);
    chk("boot_ld_ready",  32'(ld_ready),  32'd1);
    chk("boot_wr_we",     32'(mem_we),    32'd1);
    chk("boot_wr_addr",   32'(mem_addr),  32'd3);
    chk("boot_wr_data",   32'(mem_wdata), 32'h1234);

    // BOOT idle loader: fetch still ignored
    next_cycle;
    ld_valid = 1'b0;
    #1;
    chk("boot_idle_en", 32'(mem_en), 32'd0);
    chk("boot_idle_we", 32'(mem_we), 32'd0);
    chk("boot_idle_stall", 32'(cpu_stall), 32'd1);

    // Write 0xABCD@15 in the ld_done cycle
    next_cycle;
    ld_valid = 1'b1; ld_addr = 4'd15; ld_data = 16'hABCD; ld_done = 1'b1;
    #1;
    chk("done_wr_we",   32'(mem_we),    32'd1);
    chk("done_wr_addr", 32'(mem_addr),  32'd15);
    chk("done_busy",    32'(boot_busy), 32'd1);

    // RUN: fetch pc=3
    next_cycle;
    ld_valid = 1'b0; ld_done = 1'b0; fetch_req = 1'b1; fetch_addr = 16'h0003;
    #1;
    chk("run_boot_busy", 32'(boot_busy), 32'd0);
    chk("run_stall",     32'(cpu_stall), 32'd0);
    chk("run_ld_ready",  32'(ld_ready),  32'd0);
    chk("run_rd_en",     32'(mem_en),    32'd1);
    chk("run_rd_we",     32'(mem_we),    32'd0);
    chk("run_rd_addr",   32'(mem_addr),  32'd3);
    push_fetch(16'h1234);

    // pc wraps modulo 16
    next_cycle;
    fetch_addr = 16'h001F;
    #1;
    chk("wrap_1f_addr", 32'(mem_addr), 32'd15);
    push_fetch(16'hABCD);
    next_cycle;
    fetch_addr = 16'h0020;
    #1;
    chk("wrap_20_addr", 32'(mem_addr), 32'd0);
    push_fetch(16'h0000);
    next_cycle;
    fetch_addr = 16'h0010;
    #1;
    chk("wrap_10_addr", 32'(mem_addr), 32'd0);
    push_fetch(16'h0000);

    // Idle cycle in RUN
    next_cycle;
    fetch_req = 1'b0;
    #1;
    chk("idle_en",       32'(mem_en),    32'd0);
    chk("idle_ld_ready", 32'(ld_ready),  32'd1);
    chk("idle_stall",    32'(cpu_stall), 32'd0);

    // RUN write 0x5555@3 then fetch it back
    next_cycle;
    ld_valid = 1'b1; ld_addr = 4'd3; ld_data = 16'h5555;
    #1;
    chk("runwr_ready", 32'(ld_ready), 32'd1);
    chk("runwr_we",    32'(mem_we),   32'd1);
    next_cycle;
    ld_valid = 1'b0; fetch_req = 1'b1; fetch_addr = 16'h0003;
    #1;
    push_fetch(16'h5555);

    // Starvation: fetch and loader both held high
    next_cycle;
    ld_valid = 1'b1; ld_addr = 4'd5; ld_data = 16'h0F0F;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("starve_wait_ready", 32'(ld_ready),  32'd0);
      chk("starve_wait_stall", 32'(cpu_stall), 32'd0);
      chk("starve_wait_we",    32'(mem_we),    32'd0);
      push_fetch(16'h5555);
      next_cycle;
    end
    #1;
    chk("starve_force_ready", 32'(ld_ready),  32'd1);
    chk("starve_force_stall", 32'(cpu_stall), 32'd1);
    chk("starve_force_we",    32'(mem_we),    32'd1);
    chk("starve_force_addr",  32'(mem_addr),  32'd5);

    // Fetch resumes; ld_done in RUN has no effect
    next_cycle;
    ld_valid = 1'b0; fetch_addr = 16'h0005; ld_done = 1'b1;
    #1;
    chk("resume_stall", 32'(cpu_stall), 32'd0);
    chk("resume_addr",  32'(mem_addr),  32'd5);
    push_fetch(16'h0F0F);
    next_cycle;
    ld_done = 1'b0; fetch_addr = 16'h000F;
    #1;
    chk("run_done_ignored", 32'(boot_busy), 32'd0);
    push_fetch(16'hABCD);

    // Reset arrives in the cycle of a fetch: no grant, no response
    next_cycle;
    reset_n = 1'b0; fetch_addr = 16'h0003;
    #1;
    chk("rstfetch_stall", 32'(cpu_stall), 32'd1);
    chk("rstfetch_en",    32'(mem_en),    32'd0);
    next_cycle;
    reset_n = 1'b1;
    #1;
    chk("post_rst_valid", 32'(fetch_valid), 32'd0);
    chk("post_rst_busy",  32'(boot_busy),   32'd1);
    chk("post_rst_stall", 32'(cpu_stall),   32'd1);

    // Back to RUN; memory contents survived the reset
    next_cycle;
    fetch_req = 1'b0; ld_done = 1'b1;
    next_cycle;
    ld_done = 1'b0; fetch_req = 1'b1; fetch_addr = 16'h000F;
    #1;
    push_fetch(16'hABCD);
    next_cycle;
    fetch_addr = 16'h0005;
    #1;
    push_fetch(16'h0F0F);
    next_cycle;
    fetch_req = 1'b0;
    next_cycle;
    next_cycle;

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, instruction-memory word address width (16 words).
REQ-002 Parameter DATA_W, default 16, instruction word width.
REQ-003 Parameter STARVE_MAX, default 4, loader wait cycles before it is forced a grant in RUN.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 fetch_req  in  1  CPU requests an instruction fetch this cycle.
REQ-007 fetch_addr  in  16  CPU pc; only bits [ADDR_W-1:0] are used.
REQ-008 fetch_valid  out  1  fetch_data carries the word for the fetch granted the previous cycle.
REQ-009 fetch_data  out  DATA_W  fetched instruction word.
REQ-010 cpu_stall  out  1  CPU must hold pc; its fetch was not issued this cycle.
REQ-011 ld_valid  in  1  loader offers a write.
REQ-012 ld_ready  out  1  loader write accepted this cycle.
REQ-013 ld_addr  in  ADDR_W  loader write address.
REQ-014 ld_data  in  DATA_W  loader write data.
REQ-015 ld_done  in  1  one-cycle pulse: program load complete.
REQ-016 boot_busy  out  1  high while in BOOT.
REQ-017 mem_en, mem_we  out  1 each  memory port enable and write enable.
REQ-018 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W  (synchronous read, data one cycle after mem_en).

Function
REQ-019 FSM states BOOT and RUN; BOOT after reset.
REQ-020 BOOT: cpu_stall=1, boot_busy=1, fetch_req ignored, ld_ready=1.
REQ-021 Any state: write transfer when ld_valid&&ld_ready; same cycle mem_en=1, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data.
REQ-022 BOOT->RUN on the edge after ld_done=1; a write in the ld_done cycle still completes.
REQ-023 ld_done in RUN is ignored.
REQ-024 RUN, fetch_req=1, no forced loader grant: mem_en=1, mem_we=0, mem_addr=fetch_addr[ADDR_W-1:0], cpu_stall=0, ld_ready=0.
REQ-025 RUN, fetch_req=0: ld_ready=ld_valid-independent 1; cpu_stall=0.
REQ-026 Starve counter increments each RUN cycle with ld_valid=1 and ld_ready=0; saturates at STARVE_MAX; clears on transfer or ld_valid=0.
REQ-027 RUN, counter==STARVE_MAX: ld_ready=1, fetch not issued, cpu_stall=fetch_req; counter cleared next cycle.
REQ-028 fetch_valid registered: 1 the cycle after a granted fetch, else 0; latency exactly one cycle.
REQ-029 fetch_data = mem_rdata when fetch_valid=1, else all zeros.
REQ-030 Address modulo 2^ADDR_W; pc 0x0010 reads word 0; word 15 followed by word 0 needs no special handling.
REQ-031 Write then fetch of same address on next cycle returns the new word.
REQ-032 mem_en=0 and mem_we=0 in idle cycles (no request granted).

Reset
REQ-033 reset_n=0 at an edge: state=BOOT, starve counter=0, fetch_valid=0; outstanding fetch discarded.
REQ-034 During and immediately after reset: cpu_stall=1, boot_busy=1, ld_ready=1, fetch_data=0, mem_we only from a live loader transfer.
REQ-035 Reset mid-RUN returns to BOOT; memory contents untouched.

Structure
REQ-036 Shared package holds ADDR_W, DATA_W, STARVE_MAX defaults and the BOOT/RUN state encoding.
REQ-037 One sub-module imem_starve_cnt (saturating counter with inc/clear, full flag); rest in imem_arbiter.

Verification
REQ-038 Reset, write 0x1234@3, 0xABCD@15, pulse ld_done -> boot_busy falls next edge; fetch pc=3 -> fetch_valid next cycle, fetch_data=0x1234.
REQ-039 BOOT, fetch_req=1 pc=0 -> cpu_stall=1, mem_we only on loader writes, fetch_valid stays 0.
REQ-040 RUN, fetch_req and ld_valid held high -> 4 fetch grants, 5th cycle ld_ready=1, cpu_stall=1, write occurs; fetches resume next cycle.
REQ-041 RUN, pc=0x001F -> mem_addr=15, fetch_data=0xABCD; pc=0x0020 -> mem_addr=0.
REQ-042 RUN, write 0x5555@3 (fetch_req=0), fetch pc=3 next cycle -> fetch_data=0x5555.
REQ-043 reset_n=0 in cycle of a granted fetch -> fetch_valid=0 next cycle, boot_busy=1, cpu_stall=1.
